// File: rtl/xccela_ctrl_muxn_sw.sv
// rtl/xccela_ctrl_muxn_sw.sv - N:1 registered path selector with break-before-make switchover
module xccela_ctrl_muxn_sw #(
    parameter int               WIDTH    = 1,
    parameter int               NUM_IN   = 4,
    parameter int               SEL_W    = 2,
    parameter int               GAP      = 2,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0,
    parameter int               RST_SEL  = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_sel_req,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    output logic                    o_busy,
    output logic [SEL_W-1:0]        o_cur_sel,
    output logic                    o_sel_ack,
    output logic                    o_sel_err
);

    // Counter is at least one bit wide so GAP=0 builds still elaborate.
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [SEL_W-1:0] RST_SEL_V = SEL_W'(RST_SEL);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_GAP    = 1'b1
    } state_t;

    state_t             state,    nxt_state;
    logic [GAP_W-1:0]   gap_cnt,  nxt_cnt;
    logic [SEL_W-1:0]   pend_sel, nxt_pend;
    logic [SEL_W-1:0]   cur_sel,  nxt_cur;
    logic [WIDTH-1:0]   data_q,   nxt_data;
    logic               valid_q,  nxt_valid;
    logic               busy_q,   nxt_busy;
    logic               ack_q,    nxt_ack;
    logic               err_q,    nxt_err;
    logic               err_dly,  nxt_err_dly;
    logic               req_q;
    logic               req_edge;
    logic               sel_ok;

    // Channel lookup; out-of-range selects never reach here but fall back to IDLE_VAL.
    function automatic logic [WIDTH-1:0] pick(input logic [NUM_IN*WIDTH-1:0] d,
                                              input logic [SEL_W-1:0]        s);
        logic [WIDTH-1:0] r;
        r = IDLE_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(s) == k) begin
                r = d[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    assign req_edge = i_sel_req & ~req_q;
    assign sel_ok   = (int'(i_sel) < NUM_IN);

    // Next-state and next-output decode for the switchover FSM.
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = gap_cnt;
        nxt_pend    = pend_sel;
        nxt_cur     = cur_sel;
        nxt_data    = pick(i_data, cur_sel);
        nxt_valid   = 1'b1;
        nxt_busy    = 1'b0;
        nxt_ack     = 1'b0;
        nxt_err     = err_dly;
        nxt_err_dly = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (req_edge) begin
                    if (!sel_ok) begin
                        nxt_err = 1'b1;
                    end else if (i_sel == cur_sel) begin
                        nxt_ack = 1'b1;
                    end else if (GAP > 0) begin
                        nxt_state = ST_GAP;
                        nxt_cnt   = GAP_W'(GAP - 1);
                        nxt_pend  = i_sel;
                        nxt_data  = IDLE_VAL;
                        nxt_valid = 1'b0;
                        nxt_busy  = 1'b1;
                    end else begin
                        nxt_cur  = i_sel;
                        nxt_data = pick(i_data, i_sel);
                        nxt_ack  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    nxt_state = ST_ACTIVE;
                    nxt_cur   = pend_sel;
                    nxt_data  = pick(i_data, pend_sel);
                    nxt_ack   = 1'b1;
                    // A reject landing on the completion edge is reported one
                    // cycle later so ack and err never coincide.
                    nxt_err_dly = req_edge;
                end else begin
                    nxt_cnt   = gap_cnt - 1'b1;
                    nxt_data  = IDLE_VAL;
                    nxt_valid = 1'b0;
                    nxt_busy  = 1'b1;
                    nxt_err   = req_edge;
                end
            end
            default: begin
                nxt_state = ST_ACTIVE;
            end
        endcase
    end

    // State and output registers; reset parks the pad path at IDLE_VAL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_ACTIVE;
            gap_cnt  <= '0;
            pend_sel <= RST_SEL_V;
            cur_sel  <= RST_SEL_V;
            data_q   <= IDLE_VAL;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            err_dly  <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state    <= nxt_state;
            gap_cnt  <= nxt_cnt;
            pend_sel <= nxt_pend;
            cur_sel  <= nxt_cur;
            data_q   <= nxt_data;
            valid_q  <= nxt_valid;
            busy_q   <= nxt_busy;
            ack_q    <= nxt_ack;
            err_q    <= nxt_err;
            err_dly  <= nxt_err_dly;
            req_q    <= i_sel_req;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_cur_sel = cur_sel;
    assign o_sel_ack = ack_q;
    assign o_sel_err = err_q;

endmodule
